// File: rtl/sram_2p_march_bist_pkg.sv
// Shared definitions for the 2-port SRAM March C- BIST controller:
// FSM state encodings, the March C- element table, and pipeline/drain lengths.
package sram_2p_march_bist_pkg;

  // FSM state encoding (legacy-compatible constants)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RUN_A  = 3'd1;
  localparam state_t ST_RUN_B  = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  // March C- has six elements, indexed 0..5
  localparam int         MARCH_ELEMS = 6;
  localparam logic [2:0] MARCH_LAST  = 3'd5;

  // Per-element tables, bit i describes element i:
  //   0: up w0 | 1: up r0,w1 | 2: up r1,w0 | 3: down r0,w1 | 4: down r1,w0 | 5: up r0
  localparam logic [MARCH_ELEMS-1:0] EL_DOWN = 6'b011000; // descending address order
  localparam logic [MARCH_ELEMS-1:0] EL_RD   = 6'b111110; // element contains a read
  localparam logic [MARCH_ELEMS-1:0] EL_WR   = 6'b011111; // element contains a write
  localparam logic [MARCH_ELEMS-1:0] EL_RVAL = 6'b010100; // read expects all ones
  localparam logic [MARCH_ELEMS-1:0] EL_WVAL = 6'b001010; // write stores all ones

  // Cycles spent flushing the compare pipeline after the last read
  localparam int DRAIN_LEN = 2;
  // Register stages between issuing a read and comparing its data
  localparam int CMP_DEPTH = 2;

  // Table lookup that returns 0 for indices past the last element
  function automatic logic el_bit(input logic [MARCH_ELEMS-1:0] tbl, input logic [2:0] idx);
    return (idx < 3'(MARCH_ELEMS)) ? tbl[idx] : 1'b0;
  endfunction

endpackage

// File: rtl/sram_2p_march_bist_cmp.sv
// sram_2p_march_cmp: aligns expected data/address/element/port with the
// macro's read data through a CMP_DEPTH-stage pipeline, and captures the
// first miscompare into sticky fail registers.
module sram_2p_march_cmp
  import sram_2p_march_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    rd_i,
  input  logic                    port_i,
  input  logic [P_DATA_WIDTH-1:0] exp_i,
  input  logic [P_ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]              elem_i,
  input  logic [P_DATA_WIDTH-1:0] a_dout_i,
  input  logic [P_DATA_WIDTH-1:0] b_dout_i,
  output logic                    fail_o,
  output logic [P_ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]              fail_elem_o,
  output logic                    fail_port_o
);

  logic [CMP_DEPTH-1:0]    vld_q;
  logic [CMP_DEPTH-1:0]    port_q;
  logic [P_DATA_WIDTH-1:0] exp_q  [CMP_DEPTH];
  logic [P_ADDR_WIDTH-1:0] addr_q [CMP_DEPTH];
  logic [2:0]              elem_q [CMP_DEPTH];

  logic                    fail_q;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q;
  logic [2:0]              fail_elem_q;
  logic                    fail_port_q;

  logic [P_DATA_WIDTH-1:0] dout;
  logic                    miscompare;

  // Read data from whichever port issued the read now leaving the pipeline
  assign dout       = port_q[CMP_DEPTH-1] ? b_dout_i : a_dout_i;
  assign miscompare = vld_q[CMP_DEPTH-1] && (dout != exp_q[CMP_DEPTH-1]);

  // Shift the expected-value pipeline; only the valid bits need a reset
  always_ff @(posedge clk_i) begin
    // NOTE: the data stages are qualified by vld_q, so leaving them out of reset is safe and saves reset routing.
    if (rst_i) begin
      vld_q  <= '0;
      port_q <= '0;
    end else begin
      vld_q  <= {vld_q[CMP_DEPTH-2:0], rd_i};
      port_q <= {port_q[CMP_DEPTH-2:0], port_i};
    end
    exp_q[0]  <= exp_i;
    addr_q[0] <= addr_i;
    elem_q[0] <= elem_i;
    for (int i = 1; i < CMP_DEPTH; i++) begin
      exp_q[i]  <= exp_q[i-1];
      addr_q[i] <= addr_q[i-1];
      elem_q[i] <= elem_q[i-1];
    end
  end

  // Latch the first miscompare; later ones leave the capture untouched
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_port_q <= 1'b0;
    end else if (miscompare && !fail_q) begin
      fail_q      <= 1'b1;
      fail_addr_q <= addr_q[CMP_DEPTH-1];
      fail_elem_q <= elem_q[CMP_DEPTH-1];
      fail_port_q <= port_q[CMP_DEPTH-1];
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_port_o = fail_port_q;

endmodule

// File: rtl/sram_2p_march_bist.sv
// sram_2p_march_bist: March C- BIST controller for the BIST port group of
// a 2-port SRAM macro. Define SRAM_2P_MARCH_BIST_PORTB_EN to repeat the full
// March C- on port B after the port-A pass.
module sram_2p_march_bist
  import sram_2p_march_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]              FAIL_ELEM,
  output logic                    FAIL_PORT,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT,
  output logic                    B_BIST_EN,
  output logic                    B_BIST_MEN,
  output logic                    B_BIST_WEN,
  output logic                    B_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] B_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] B_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] B_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] B_DOUT
);

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = {P_ADDR_WIDTH{1'b1}};
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [P_DATA_WIDTH-1:0] DATA_ONES = {P_DATA_WIDTH{1'b1}};

  state_t                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    phase_q, phase_d;   // 0 = read slot, 1 = write slot
  logic                    drain_q, drain_d;
  logic                    busy_q, done_q;

  logic                    el_rw, op_rd, op_wr, down, addr_done, addr_term;
  logic                    running, start_ok, a_act;
  logic [P_DATA_WIDTH-1:0] din_d;

  // Decode the current March operation and compute the next sequencer state
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    drain_d   = drain_q;
    el_rw     = el_bit(EL_RD, elem_q) && el_bit(EL_WR, elem_q);
    op_rd     = el_bit(EL_RD, elem_q) && !phase_q;
    op_wr     = el_bit(EL_WR, elem_q) && (phase_q || !el_bit(EL_RD, elem_q));
    down      = el_bit(EL_DOWN, elem_q);
    addr_done = !el_rw || phase_q;
    addr_term = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    running   = (state_q == ST_RUN_A) || (state_q == ST_RUN_B);
    start_ok  = START && ((state_q == ST_IDLE) || (state_q == ST_FINISH));

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start_ok) begin
          state_d = ST_RUN_A;
          elem_d  = '0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      ST_RUN_A, ST_RUN_B: begin
        if (el_rw) phase_d = !phase_q;
        if (addr_done) begin
          addr_d = down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          if (addr_term) begin
            if (elem_q != MARCH_LAST) begin
              elem_d = elem_q + 3'd1;
              addr_d = el_bit(EL_DOWN, elem_q + 3'd1) ? ADDR_MAX : '0;
            end else begin
              elem_d  = '0;
              addr_d  = '0;
              drain_d = 1'b0;
`ifdef SRAM_2P_MARCH_BIST_PORTB_EN
              state_d = (state_q == ST_RUN_A) ? ST_RUN_B : ST_DRAIN;
`else
              state_d = ST_DRAIN;
`endif
            end
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == 1'(DRAIN_LEN - 1)) state_d = ST_FINISH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign a_act = (state_q == ST_RUN_A);
  assign din_d = (op_wr && el_bit(EL_WVAL, elem_q)) ? DATA_ONES : '0;

  // Sequencer state plus BUSY/DONE status
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      drain_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
      if (start_ok) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end else if (state_q == ST_DRAIN && state_d == ST_FINISH) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  logic                    a_en_q, a_wen_q, a_ren_q;
  logic [P_ADDR_WIDTH-1:0] a_addr_q;
  logic [P_DATA_WIDTH-1:0] a_din_q, a_bm_q;

  // Registered port-A BIST controls; all zero outside the port-A pass
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_en_q   <= 1'b0;
      a_wen_q  <= 1'b0;
      a_ren_q  <= 1'b0;
      a_addr_q <= '0;
      a_din_q  <= '0;
      a_bm_q   <= '0;
    end else begin
      a_en_q   <= a_act;
      a_wen_q  <= a_act && op_wr;
      a_ren_q  <= a_act && op_rd;
      a_addr_q <= a_act ? addr_q : '0;
      a_din_q  <= a_act ? din_d : '0;
      a_bm_q   <= a_act ? DATA_ONES : '0;
    end
  end

  assign A_BIST_EN   = a_en_q;
  assign A_BIST_MEN  = a_en_q;
  assign A_BIST_WEN  = a_wen_q;
  assign A_BIST_REN  = a_ren_q;
  assign A_BIST_ADDR = a_addr_q;
  assign A_BIST_DIN  = a_din_q;
  assign A_BIST_BM   = a_bm_q;

`ifdef SRAM_2P_MARCH_BIST_PORTB_EN
  logic                    b_act;
  logic                    b_en_q, b_wen_q, b_ren_q;
  logic [P_ADDR_WIDTH-1:0] b_addr_q;
  logic [P_DATA_WIDTH-1:0] b_din_q, b_bm_q;

  assign b_act = (state_q == ST_RUN_B);

  // Registered port-B BIST controls; all zero outside the port-B pass
  always_ff @(posedge CLK) begin
    if (RST) begin
      b_en_q   <= 1'b0;
      b_wen_q  <= 1'b0;
      b_ren_q  <= 1'b0;
      b_addr_q <= '0;
      b_din_q  <= '0;
      b_bm_q   <= '0;
    end else begin
      b_en_q   <= b_act;
      b_wen_q  <= b_act && op_wr;
      b_ren_q  <= b_act && op_rd;
      b_addr_q <= b_act ? addr_q : '0;
      b_din_q  <= b_act ? din_d : '0;
      b_bm_q   <= b_act ? DATA_ONES : '0;
    end
  end

  assign B_BIST_EN   = b_en_q;
  assign B_BIST_MEN  = b_en_q;
  assign B_BIST_WEN  = b_wen_q;
  assign B_BIST_REN  = b_ren_q;
  assign B_BIST_ADDR = b_addr_q;
  assign B_BIST_DIN  = b_din_q;
  assign B_BIST_BM   = b_bm_q;
`else
  assign B_BIST_EN   = 1'b0;
  assign B_BIST_MEN  = 1'b0;
  assign B_BIST_WEN  = 1'b0;
  assign B_BIST_REN  = 1'b0;
  assign B_BIST_ADDR = '0;
  assign B_BIST_DIN  = '0;
  assign B_BIST_BM   = '0;
`endif

  sram_2p_march_cmp #(
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .P_ADDR_WIDTH(P_ADDR_WIDTH)
  ) u_cmp (
    .clk_i       (CLK),
    .rst_i       (RST),
    .clr_i       (start_ok),
    .rd_i        (running && op_rd),
    .port_i      (state_q == ST_RUN_B),
    .exp_i       ({P_DATA_WIDTH{el_bit(EL_RVAL, elem_q)}}),
    .addr_i      (addr_q),
    .elem_i      (elem_q),
    .a_dout_i    (A_DOUT),
    .b_dout_i    (B_DOUT),
    .fail_o      (FAIL),
    .fail_addr_o (FAIL_ADDR),
    .fail_elem_o (FAIL_ELEM),
    .fail_port_o (FAIL_PORT)
  );

  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_sram_2p_march_bist.sv
// Self-checking bench for sram_2p_march_bist with a behavioral 2-port SRAM
// whose read paths can carry a stuck-at fault on a chosen address and bit.
module tb_sram_2p_march_bist;

  localparam int DW       = 8;
  localparam int AW       = 8;
  localparam int N        = 1 << AW;
  localparam int PASS_LEN = 10 * N;
`ifdef SRAM_2P_MARCH_BIST_PORTB_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int DONE_K = PASSES * PASS_LEN + 3;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, fail, fail_port;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic a_en, a_men, a_wen, a_ren, b_en, b_men, b_wen, b_ren;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, a_bm, a_dout, b_din, b_bm, b_dout;

  always #5 clk = ~clk;

  sram_2p_march_bist #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
    .CLK(clk), .RST(rst), .START(start),
    .BUSY(busy), .DONE(done), .FAIL(fail),
    .FAIL_ADDR(fail_addr), .FAIL_ELEM(fail_elem), .FAIL_PORT(fail_port),
    .A_BIST_EN(a_en), .A_BIST_MEN(a_men), .A_BIST_WEN(a_wen), .A_BIST_REN(a_ren),
    .A_BIST_ADDR(a_addr), .A_BIST_DIN(a_din), .A_BIST_BM(a_bm), .A_DOUT(a_dout),
    .B_BIST_EN(b_en), .B_BIST_MEN(b_men), .B_BIST_WEN(b_wen), .B_BIST_REN(b_ren),
    .B_BIST_ADDR(b_addr), .B_BIST_DIN(b_din), .B_BIST_BM(b_bm), .B_DOUT(b_dout)
  );

  // Behavioral SRAM with fault injection on the read paths
  logic [DW-1:0] mem [N];
  bit            f_on_a, f_on_b, f_val;
  logic [AW-1:0] f_addr;
  int            f_bit;

  function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] d, input logic [AW-1:0] a, input bit on);
    logic [DW-1:0] r;
    r = d;
    if (on && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (a_en && a_men) begin
      if (a_wen) mem[a_addr] <= (mem[a_addr] & ~a_bm) | (a_din & a_bm);
      if (a_ren) a_dout <= rd_fault(mem[a_addr], a_addr, f_on_a);
    end
    if (b_en && b_men) begin
      if (b_wen) mem[b_addr] <= (mem[b_addr] & ~b_bm) | (b_din & b_bm);
      if (b_ren) b_dout <= rd_fault(mem[b_addr], b_addr, f_on_b);
    end
  end

  logic b_any, all_out;
  assign b_any   = b_en | b_men | b_wen | b_ren | (|b_addr) | (|b_din) | (|b_bm);
  assign all_out = busy | done | fail | (|fail_addr) | (|fail_elem) | fail_port |
                   a_en | a_men | a_wen | a_ren | (|a_addr) | (|a_din) | (|a_bm) | b_any;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    bit            fault_a;
    bit            fault_b;
    logic [AW-1:0] addr;
    int            bitn;
    bit            val;
    int            repulse_at;
    bit            exp_fail;
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_elem;
    bit            exp_port;
  } vec_t;

  // Pulse START, run one full test, compare timing, port activity and capture
  task automatic run_row(input vec_t v);
    int k, done_k, a_bad, b_bad;
    f_on_a = v.fault_a; f_on_b = v.fault_b;
    f_addr = v.addr;    f_bit  = v.bitn;    f_val = v.val;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 1;
    check("busy_at_plus1", busy, 1);
    check("done_cleared_by_start", done, 0);
    check("fail_cleared_by_start", fail, 0);
    done_k = -1; a_bad = 0; b_bad = 0;
    while (k <= DONE_K + 20) begin
      if (done) begin
        done_k = k;
        break;
      end
      if (a_en !== (k >= 2 && k <= PASS_LEN + 1)) a_bad++;
      if (b_any !== (PASSES == 2 && k >= PASS_LEN + 2 && k <= 2 * PASS_LEN + 1)) b_bad++;
      start = (k == v.repulse_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("done_cycle", done_k, DONE_K);
    check("busy_low_at_done", busy, 0);
    check("fail", fail, v.exp_fail);
    check("fail_addr", fail_addr, v.exp_addr);
    check("fail_elem", fail_elem, v.exp_elem);
    check("fail_port", fail_port, v.exp_port);
    check("a_en_window_errors", a_bad, 0);
    check("b_port_window_errors", b_bad, 0);
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 8'hA5;
    a_dout = '0; b_dout = '0;
    f_on_a = 0; f_on_b = 0; f_addr = '0; f_bit = 0; f_val = 0;
    rst = 1'b1; start = 1'b0;

    //           fA fB addr   bit v  rep  fail addr  elem port
    vecs.push_back('{0, 0, 8'h00, 0, 0, -1, 0, 8'h00, 3'd0, 0}); // clean run
    vecs.push_back('{1, 1, 8'h5A, 3, 0, -1, 1, 8'h5A, 3'd2, 0}); // bit3 SA0 at 0x5A
    vecs.push_back('{1, 1, 8'hFF, 0, 1, -1, 1, 8'hFF, 3'd1, 0}); // bit0 SA1 at 0xFF
    vecs.push_back('{0, 0, 8'h00, 0, 0, 50, 0, 8'h00, 3'd0, 0}); // START re-pulsed while busy
    vecs.push_back('{1, 1, 8'h00, 7, 1, -1, 1, 8'h00, 3'd1, 0}); // bit7 SA1 at 0x00
`ifdef SRAM_2P_MARCH_BIST_PORTB_EN
    vecs.push_back('{0, 1, 8'h10, 0, 1, -1, 1, 8'h10, 3'd1, 1}); // port-B-only fault at 0x10
`endif

    repeat (3) @(negedge clk);
    check("outputs_in_reset", all_out, 0);
    rst = 1'b0;
    @(negedge clk);
    check("outputs_after_reset", all_out, 0);

    foreach (vecs[i]) run_row(vecs[i]);

    // Reset in the middle of a run, then a clean rerun
    f_on_a = 0; f_on_b = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("outputs_after_midrun_reset", all_out, 0);
    rst = 1'b0;
    @(negedge clk);
    run_row(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
